// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory sequencer state encoding and the default
// memory-bus timing used when the CPU instantiates mem_access_unit.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SLOT = 2'd1,
        DONE = 2'd2,
        ERR  = 2'd3
    } mem_access_state_t;

    localparam int MEM_WAIT_CYCLES = 4;
    localparam int MEM_MAX_BYTES   = 2;

endpackage

// File: rtl/mem_slot_counter.sv
// Nested wait/byte counters for mem_access_unit: w walks 0..WAIT_CYCLES-1
// inside each byte slot, k walks the byte slots of one access.
module mem_slot_counter #(
    parameter int WAIT_CYCLES = 4,
    parameter int MAX_BYTES   = 2,
    parameter int LEN_W       = $clog2(MAX_BYTES) + 1,
    parameter int K_W         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic [LEN_W-1:0] len,
    output logic [K_W-1:0]   slot_idx,
    output logic             slot_start,
    output logic             slot_end,
    output logic             last_slot
);

    localparam int             W_W    = $clog2(WAIT_CYCLES);
    localparam logic [W_W-1:0] W_LAST = W_W'(WAIT_CYCLES - 1);

    logic [W_W-1:0] w_r;
    logic [K_W-1:0] k_r;

    assign slot_idx   = k_r;
    assign slot_start = run && (w_r == {W_W{1'b0}});
    assign slot_end   = run && (w_r == W_LAST);
    assign last_slot  = ((LEN_W'(k_r) + LEN_W'(1)) == len);

    // w advances every running cycle; k advances only at a non-final slot end.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_r <= {W_W{1'b0}};
            k_r <= {K_W{1'b0}};
        end else if (start) begin
            w_r <= {W_W{1'b0}};
            k_r <= {K_W{1'b0}};
        end else if (slot_end) begin
            w_r <= {W_W{1'b0}};
            if (!last_slot) begin
                k_r <= k_r + K_W'(1);
            end else begin
                k_r <= k_r;
            end
        end else if (run) begin
            w_r <= w_r + W_W'(1);
        end else begin
            w_r <= w_r;
            k_r <= k_r;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Multi-byte little-endian read/write sequencer for the 8-bit memory bus.
// Optional feature macro MEM_ACCESS_SEXT_EN enables read sign extension (req_sext).
module mem_access_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH  = 16,
    parameter int MAX_BYTES   = MEM_MAX_BYTES,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
    parameter int LEN_W       = $clog2(MAX_BYTES) + 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [LEN_W-1:0]       req_len,
    input  logic [8*MAX_BYTES-1:0] req_wdata,
    input  logic                   req_sext,
    output logic                   rsp_valid,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [7:0]             mem_data_write,
    input  logic [7:0]             mem_data_read,
    output logic                   mem_do_write
);

    localparam int DW  = 8 * MAX_BYTES;
    localparam int K_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

    mem_access_state_t state_r;
    logic              write_r;
    logic [LEN_W-1:0]  len_r;
    logic [DW-1:0]     wdata_r;
    logic [DW-1:0]     rdata_r;

    logic              accept_s;
    logic              legal_s;
    logic              capture_s;
    logic [DW-1:0]     wdata_shift_s;
    logic [DW-1:0]     rdata_next_s;
    logic [DW-1:0]     rsp_next_s;
    logic [7:0]        fill_s;
    logic [K_W-1:0]    slot_idx_s;
    logic              slot_start_s;
    logic              slot_end_s;
    logic              last_slot_s;

`ifdef MEM_ACCESS_SEXT_EN
    logic              sext_r;
`else
    logic              unused_sext_s;
    assign unused_sext_s = req_sext;
`endif

    assign accept_s      = req_valid && req_ready && (state_r == IDLE);
    assign legal_s       = (req_len != {LEN_W{1'b0}}) && (req_len <= LEN_W'(MAX_BYTES));
    assign capture_s     = (state_r == SLOT) && slot_end_s && !write_r;
    assign wdata_shift_s = wdata_r >> 4'd8;

    mem_slot_counter #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .MAX_BYTES   (MAX_BYTES),
        .LEN_W       (LEN_W),
        .K_W         (K_W)
    ) u_slot_counter (
        .clk        (clk),
        .reset      (reset),
        .start      (accept_s),
        .run        (state_r == SLOT),
        .len        (len_r),
        .slot_idx   (slot_idx_s),
        .slot_start (slot_start_s),
        .slot_end   (slot_end_s),
        .last_slot  (last_slot_s)
    );

    // Merge the byte arriving this cycle so the final byte reaches the response in the same edge.
    always_comb begin
        rdata_next_s = rdata_r;
        rsp_next_s   = {DW{1'b0}};
        fill_s       = 8'h00;
        if (capture_s) begin
            rdata_next_s[{slot_idx_s, 3'b000} +: 8] = mem_data_read;
        end else begin
            rdata_next_s = rdata_r;
        end
`ifdef MEM_ACCESS_SEXT_EN
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (sext_r && (LEN_W'(i + 1) == len_r)) begin
                fill_s = {8{rdata_next_s[8*i+7]}};
            end else begin
                fill_s = fill_s;
            end
        end
`endif
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (LEN_W'(i) < len_r) begin
                rsp_next_s[8*i +: 8] = rdata_next_s[8*i +: 8];
            end else begin
                rsp_next_s[8*i +: 8] = fill_s;
            end
        end
    end

    // Sequencer FSM; all bus and response outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            req_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_rdata      <= {DW{1'b0}};
            mem_addr       <= {ADDR_WIDTH{1'b0}};
            mem_data_write <= 8'h00;
            mem_do_write   <= 1'b0;
            write_r        <= 1'b0;
            len_r          <= {LEN_W{1'b0}};
            wdata_r        <= {DW{1'b0}};
            rdata_r        <= {DW{1'b0}};
`ifdef MEM_ACCESS_SEXT_EN
            sext_r         <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    rsp_valid    <= 1'b0;
                    rsp_err      <= 1'b0;
                    mem_do_write <= 1'b0;
                    if (accept_s) begin
                        req_ready <= 1'b0;
                        write_r   <= req_write;
                        len_r     <= req_len;
                        wdata_r   <= req_wdata;
                        rdata_r   <= {DW{1'b0}};
`ifdef MEM_ACCESS_SEXT_EN
                        sext_r    <= req_sext;
`endif
                        if (legal_s) begin
                            state_r      <= SLOT;
                            mem_addr     <= req_addr;
                            mem_do_write <= req_write;
                            if (req_write) begin
                                mem_data_write <= req_wdata[7:0];
                            end
                        end else begin
                            // Illegal length: answer immediately, leave the bus untouched.
                            state_r   <= ERR;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= {DW{1'b0}};
                        end
                    end else begin
                        state_r   <= IDLE;
                        req_ready <= 1'b1;
                    end
                end
                SLOT: begin
                    if (slot_end_s) begin
                        rdata_r <= rdata_next_s;
                        if (last_slot_s) begin
                            state_r      <= DONE;
                            rsp_valid    <= 1'b1;
                            rsp_err      <= 1'b0;
                            mem_do_write <= 1'b0;
                            rsp_rdata    <= write_r ? {DW{1'b0}} : rsp_next_s;
                        end else begin
                            mem_addr     <= mem_addr + ADDR_WIDTH'(1);
                            mem_do_write <= write_r;
                            if (write_r) begin
                                mem_data_write <= wdata_shift_s[7:0];
                                wdata_r        <= wdata_shift_s;
                            end
                        end
                    end else if (slot_start_s) begin
                        mem_do_write <= 1'b0;
                    end
                end
                DONE, ERR: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    req_ready    <= 1'b1;
                    rsp_valid    <= 1'b0;
                    rsp_err      <= 1'b0;
                    mem_do_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: default instance (2 bytes, 4 waits)
// plus a wide instance (4 bytes, 2 waits), each with its own registered memory.
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SEXT_EN
    localparam bit SEXT_ON = 1'b1;
`else
    localparam bit SEXT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        a_req_valid = 1'b0, a_req_ready, a_req_write = 1'b0, a_req_sext = 1'b0;
    logic [15:0] a_req_addr = 16'h0, a_req_wdata = 16'h0, a_rsp_rdata, a_mem_addr;
    logic [1:0]  a_req_len = 2'd0;
    logic        a_rsp_valid, a_rsp_err, a_mem_do_write;
    logic [7:0]  a_mem_data_write, a_mem_data_read = 8'h00;

    logic        b_req_valid = 1'b0, b_req_ready, b_req_write = 1'b0, b_req_sext = 1'b0;
    logic [15:0] b_req_addr = 16'h0, b_mem_addr;
    logic [2:0]  b_req_len = 3'd0;
    logic [31:0] b_req_wdata = 32'h0, b_rsp_rdata;
    logic        b_rsp_valid, b_rsp_err, b_mem_do_write;
    logic [7:0]  b_mem_data_write, b_mem_data_read = 8'h00;

    bit [7:0]    mem_a [0:65535];
    bit [7:0]    mem_b [0:65535];
    bit [7:0]    shadow_a [0:65535];
    logic        pl_en = 1'b0, pl_sel = 1'b0;
    logic [15:0] pl_addr = 16'h0;
    logic [7:0]  pl_data = 8'h00;

    int          n_checks = 0;
    int          n_fail = 0;
    int          st_n[$];
    logic [15:0] st_addr[$];
    logic [7:0]  st_data[$];
    logic [15:0] addr_seen[$];

    always #5 clk = ~clk;

    mem_access_unit u_dut (
        .clk(clk), .reset(reset), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_write(a_req_write), .req_addr(a_req_addr), .req_len(a_req_len),
        .req_wdata(a_req_wdata), .req_sext(a_req_sext), .rsp_valid(a_rsp_valid),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err), .mem_addr(a_mem_addr),
        .mem_data_write(a_mem_data_write), .mem_data_read(a_mem_data_read),
        .mem_do_write(a_mem_do_write)
    );

    mem_access_unit #(.ADDR_WIDTH(16), .MAX_BYTES(4), .WAIT_CYCLES(2)) u_dut_wide (
        .clk(clk), .reset(reset), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_write(b_req_write), .req_addr(b_req_addr), .req_len(b_req_len),
        .req_wdata(b_req_wdata), .req_sext(b_req_sext), .rsp_valid(b_rsp_valid),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err), .mem_addr(b_mem_addr),
        .mem_data_write(b_mem_data_write), .mem_data_read(b_mem_data_read),
        .mem_do_write(b_mem_do_write)
    );

    // Registered-read memories; backdoor preload has priority over the bus.
    always @(posedge clk) begin
        if (pl_en && !pl_sel) mem_a[pl_addr] <= pl_data;
        else if (a_mem_do_write) mem_a[a_mem_addr] <= a_mem_data_write;
        if (pl_en && pl_sel) mem_b[pl_addr] <= pl_data;
        else if (b_mem_do_write) mem_b[b_mem_addr] <= b_mem_data_write;
        a_mem_data_read <= mem_a[a_mem_addr];
        b_mem_data_read <= mem_b[b_mem_addr];
    end

    // Reference read: little-endian bytes from the shadow memory, two's-complement sign extension.
    function automatic logic [15:0] model_read(input logic [15:0] ad, input int ln, input bit sx);
        longint v;
        v = 0;
        for (int k = 0; k < ln; k++) v += longint'(shadow_a[16'(ad + 16'(k))]) << (8 * k);
        if (SEXT_ON && sx && (v >= (longint'(1) << (8 * ln - 1)))) v -= longint'(1) << (8 * ln);
        return v[15:0];
    endfunction

    task automatic preload(input bit sel, input logic [15:0] ad, input logic [7:0] d);
        pl_en = 1'b1; pl_sel = sel; pl_addr = ad; pl_data = d;
        if (!sel) shadow_a[ad] = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Issues one request on the default instance at the current negedge and observes it.
    task automatic run_access(input bit wr, input logic [15:0] ad, input logic [1:0] ln,
                              input logic [15:0] wd, input bit sx, output int lat,
                              output logic [15:0] rd, output logic er, output logic rdy);
        st_n.delete(); st_addr.delete(); st_data.delete(); addr_seen.delete();
        lat = -1; rd = 16'h0; er = 1'b0; rdy = 1'b0;
        a_req_valid = 1'b1; a_req_write = wr; a_req_addr = ad; a_req_len = ln;
        a_req_wdata = wd; a_req_sext = sx;
        @(negedge clk);
        a_req_valid = 1'b0; a_req_addr = 16'($urandom); a_req_wdata = 16'($urandom);
        a_req_len = 2'($urandom);
        for (int n = 1; n <= 40; n++) begin
            if (a_mem_do_write) begin
                st_n.push_back(n); st_addr.push_back(a_mem_addr); st_data.push_back(a_mem_data_write);
            end
            addr_seen.push_back(a_mem_addr);
            if (lat >= 0) begin
                rdy = a_req_ready;
                break;
            end
            if (a_rsp_valid) begin
                lat = n; rd = a_rsp_rdata; er = a_rsp_err;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++; if (a_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", a_req_ready); end
        n_checks++; if (a_rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); end
        n_checks++; if (a_rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got %b want 0", a_rsp_err); end
        n_checks++; if (a_rsp_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", a_rsp_rdata); end
        n_checks++; if (a_mem_addr !== 16'h0) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0", a_mem_addr); end
        n_checks++; if (a_mem_do_write !== 1'b0 || a_mem_data_write !== 8'h00) begin
            n_fail++; $display("FAIL reset_mem_write got we=%b d=%h want 0/00", a_mem_do_write, a_mem_data_write); end
        n_checks++; if (b_req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wide_ready got %b want 1", b_req_ready); end
    endtask

    task automatic test_read_basic();
        int lat; logic [15:0] rd; logic er, rdy;
        preload(1'b0, 16'h1234, 8'hCD);
        preload(1'b0, 16'h1235, 8'hAB);
        run_access(1'b0, 16'h1234, 2'd2, 16'($urandom), 1'b0, lat, rd, er, rdy);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL read_latency got %0d want 9", lat); end
        n_checks++; if (rd !== 16'hABCD) begin n_fail++; $display("FAIL read_data got %h want abcd", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL read_err got %b want 0", er); end
        n_checks++; if (st_n.size() !== 0) begin n_fail++; $display("FAIL read_strobes got %0d want 0", st_n.size()); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL read_ready_after got %b want 1", rdy); end
    endtask

    task automatic test_write_wrap();
        int lat; logic [15:0] rd; logic er, rdy;
        run_access(1'b1, 16'hFFFF, 2'd2, 16'h5A3C, 1'b0, lat, rd, er, rdy);
        shadow_a[16'hFFFF] = 8'h3C; shadow_a[16'h0000] = 8'h5A;
        n_checks++; if (st_n.size() !== 2) begin n_fail++; $display("FAIL write_strobe_count got %0d want 2", st_n.size()); end
        if (st_n.size() == 2) begin
            n_checks++; if (st_n[0] !== 1 || st_addr[0] !== 16'hFFFF || st_data[0] !== 8'h3C) begin n_fail++;
                $display("FAIL write_byte0 got n=%0d a=%h d=%h want 1/ffff/3c", st_n[0], st_addr[0], st_data[0]); end
            n_checks++; if (st_n[1] !== 5 || st_addr[1] !== 16'h0000 || st_data[1] !== 8'h5A) begin n_fail++;
                $display("FAIL write_byte1 got n=%0d a=%h d=%h want 5/0000/5a", st_n[1], st_addr[1], st_data[1]); end
        end
        n_checks++; if (lat !== 9 || rd !== 16'h0 || er !== 1'b0) begin n_fail++;
            $display("FAIL write_rsp got lat=%0d rd=%h err=%b want 9/0000/0", lat, rd, er); end
        run_access(1'b0, 16'hFFFF, 2'd2, 16'($urandom), 1'b0, lat, rd, er, rdy);
        n_checks++; if (rd !== model_read(16'hFFFF, 2, 1'b0)) begin n_fail++;
            $display("FAIL write_readback got %h want %h", rd, model_read(16'hFFFF, 2, 1'b0)); end
    endtask

    task automatic test_sext();
        int lat; logic [15:0] rd; logic er, rdy;
        logic [15:0] want;
        preload(1'b0, 16'h0100, 8'h80);
        preload(1'b0, 16'h0101, 8'h7F);
        want = SEXT_ON ? 16'hFF80 : 16'h0080;
        run_access(1'b0, 16'h0100, 2'd1, 16'($urandom), 1'b1, lat, rd, er, rdy);
        n_checks++; if (rd !== want) begin n_fail++; $display("FAIL sext_on got %h want %h", rd, want); end
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sext_len1_latency got %0d want 5", lat); end
        run_access(1'b0, 16'h0100, 2'd1, 16'($urandom), 1'b0, lat, rd, er, rdy);
        n_checks++; if (rd !== 16'h0080) begin n_fail++; $display("FAIL sext_off got %h want 0080", rd); end
        run_access(1'b0, 16'h0101, 2'd1, 16'($urandom), 1'b1, lat, rd, er, rdy);
        n_checks++; if (rd !== 16'h007F) begin n_fail++; $display("FAIL sext_positive got %h want 007f", rd); end
    endtask

    task automatic test_err_len();
        int lat; logic [15:0] rd; logic er, rdy;
        logic [15:0] pre;
        int moved;
        logic [1:0] bad_len [2];
        bad_len[0] = 2'd0; bad_len[1] = 2'd3;
        for (int i = 0; i < 2; i++) begin
            pre = a_mem_addr;
            run_access(1'b1, 16'($urandom), bad_len[i], 16'($urandom), 1'b0, lat, rd, er, rdy);
            moved = 0;
            foreach (addr_seen[j]) if (addr_seen[j] !== pre) moved++;
            n_checks++; if (lat !== 1 || er !== 1'b1 || rd !== 16'h0) begin n_fail++;
                $display("FAIL err_len%0d_rsp got lat=%0d err=%b rd=%h want 1/1/0000", bad_len[i], lat, er, rd); end
            n_checks++; if (st_n.size() !== 0 || moved !== 0) begin n_fail++;
                $display("FAIL err_len%0d_bus got strobes=%0d addr_moves=%0d want 0/0", bad_len[i], st_n.size(), moved); end
            n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL err_len%0d_ready got %b want 1", bad_len[i], rdy); end
        end
    endtask

    task automatic test_reset_mid();
        int lat; logic [15:0] rd; logic er, rdy;
        int late_rsp;
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 16'h0300; a_req_len = 2'd2;
        a_req_wdata = 16'hBEEF; a_req_sext = 1'b0;
        @(negedge clk);
        a_req_valid = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (a_mem_do_write !== 1'b1 || a_mem_addr !== 16'h0301) begin n_fail++;
            $display("FAIL midrst_slot1_strobe got we=%b a=%h want 1/0301", a_mem_do_write, a_mem_addr); end
        shadow_a[16'h0300] = 8'hEF; shadow_a[16'h0301] = 8'hBE;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++; if (a_mem_do_write !== 1'b0 || a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0 || a_mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL midrst_state got we=%b rdy=%b rv=%b a=%h want 0/1/0/0000",
                               a_mem_do_write, a_req_ready, a_rsp_valid, a_mem_addr); end
        late_rsp = 0;
        repeat (12) begin
            if (a_rsp_valid || a_mem_do_write) late_rsp++;
            @(negedge clk);
        end
        n_checks++; if (late_rsp !== 0) begin n_fail++; $display("FAIL midrst_no_rsp got %0d events want 0", late_rsp); end
        run_access(1'b0, 16'h0300, 2'd2, 16'($urandom), 1'b0, lat, rd, er, rdy);
        n_checks++; if (lat !== 9 || rd !== 16'hBEEF) begin n_fail++;
            $display("FAIL midrst_fresh_read got lat=%0d rd=%h want 9/beef", lat, rd); end
    endtask

    task automatic test_wide();
        int lat; logic [31:0] rd; logic er, rdy;
        int writes, bad_addr, extra;
        preload(1'b1, 16'h2000, 8'h11);
        preload(1'b1, 16'h2001, 8'h22);
        preload(1'b1, 16'h2002, 8'h33);
        preload(1'b1, 16'h2003, 8'hC4);
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 16'h2000; b_req_len = 3'd3;
        b_req_wdata = $urandom; b_req_sext = 1'b0;
        @(negedge clk);
        lat = -1; rd = 32'h0; er = 1'b0; rdy = 1'b0; writes = 0; bad_addr = 0; extra = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == 3) begin
                b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 16'h5555; b_req_len = 3'd1;
            end else begin
                b_req_valid = 1'b0;
            end
            if (b_mem_do_write) writes++;
            if (b_mem_addr < 16'h2000 || b_mem_addr > 16'h2002) bad_addr++;
            if (b_rsp_valid && lat < 0) begin lat = n; rd = b_rsp_rdata; er = b_rsp_err; end
            else if (b_rsp_valid) extra++;
            if (lat >= 0 && n == lat + 1) rdy = b_req_ready;
            @(negedge clk);
        end
        n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL wide_latency got %0d want 7", lat); end
        n_checks++; if (rd !== 32'h00332211 || er !== 1'b0) begin n_fail++;
            $display("FAIL wide_data got %h err=%b want 00332211/0", rd, er); end
        n_checks++; if (writes !== 0 || extra !== 0 || bad_addr !== 0) begin n_fail++;
            $display("FAIL wide_ignore_midreq got writes=%0d extra_rsp=%0d bad_addr=%0d want 0/0/0", writes, extra, bad_addr); end
        n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL wide_ready_after got %b want 1", rdy); end
    endtask

    task automatic test_random_back_to_back();
        int lat; logic [15:0] rd; logic er, rdy;
        bit wr, sx;
        int ln, want_lat;
        logic [15:0] ad, wd, want_rd;
        for (int i = 0; i < 32; i++) preload(1'b0, 16'(16'hFFF0 + 16'(i)), 8'($urandom));
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            ad = 16'(16'hFFF8 + 16'($urandom_range(0, 13)));
            wd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) ln = $urandom_range(0, 1) ? 3 : 0;
            else ln = $urandom_range(1, 2);
            want_lat = (ln >= 1 && ln <= 2) ? ln * 4 + 1 : 1;
            want_rd = (wr || ln == 0 || ln == 3) ? 16'h0 : model_read(ad, ln, sx);
            run_access(wr, ad, 2'(ln), wd, sx, lat, rd, er, rdy);
            if (wr && ln >= 1 && ln <= 2)
                for (int k = 0; k < ln; k++) shadow_a[16'(ad + 16'(k))] = wd[8*k +: 8];
            n_checks++; if (lat !== want_lat || er !== (ln == 0 || ln == 3)) begin n_fail++;
                $display("FAIL rand%0d_timing wr=%b len=%0d got lat=%0d err=%b want %0d/%b", i, wr, ln, lat, er,
                         want_lat, (ln == 0 || ln == 3)); end
            n_checks++; if (rd !== want_rd) begin n_fail++;
                $display("FAIL rand%0d_data wr=%b a=%h len=%0d sx=%b got %h want %h", i, wr, ad, ln, sx, rd, want_rd); end
            n_checks++; if (st_n.size() !== ((wr && ln >= 1 && ln <= 2) ? ln : 0)) begin n_fail++;
                $display("FAIL rand%0d_strobes got %0d", i, st_n.size()); end
        end
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wrap();
        test_sext();
        test_err_len();
        test_reset_mid();
        test_wide();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not complete within 500000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised multi-byte memory sequencer for the CPU's 8-bit memory bus. It runs 1..MAX_BYTES consecutive byte reads or writes, little-endian, at a configurable per-byte bus latency. It replaces the CPU's hard-wired DECODE_MEM1..8 operand stages, and adds the writes needed for stores and pushes. The CPU raises one request and receives one response per multi-byte access.

## Interface
- ADDR_WIDTH, 16: memory address width.
- MAX_BYTES, 2: maximum bytes per request, ≥1.
- WAIT_CYCLES, 4: bus cycles per byte slot, ≥2.
- LEN_W, $clog2(MAX_BYTES)+1 (derived): width of req_len.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  high only in IDLE; request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  address of byte 0.
- req_len  in  LEN_W  byte count, legal range 1..MAX_BYTES.
- req_wdata  in  8*MAX_BYTES  write data; byte k is [8k+7:8k].
- req_sext  in  1  sign-extend read data from the last byte read.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  8*MAX_BYTES  assembled read data; held until the next accept.
- rsp_err  out  1  qualifies rsp_valid; set on an illegal req_len.
- mem_addr  out  ADDR_WIDTH  bus address.
- mem_data_write  out  8  bus write data.
- mem_data_read  in  8  bus read data, registered by memory; valid from the cycle after the address.
- mem_do_write  out  1  write strobe.

## Operation
- States: IDLE, SLOT, DONE, ERR.
- IDLE → SLOT on accept with 1 ≤ req_len ≤ MAX_BYTES. IDLE → ERR on accept with an illegal req_len. No bus activity in the ERR path.
- On accept, the block latches write, addr, len, wdata and sext, and clears the byte index k and the wait counter w.
- SLOT, w = 0:
  - mem_addr = (addr + k) mod 2^ADDR_WIDTH; the address wraps with no error.
  - For writes, mem_do_write = 1 and mem_data_write = wdata byte k.
  - mem_do_write is high only in the w = 0 cycle of a write slot.
- SLOT, w = WAIT_CYCLES−1:
  - For reads, mem_data_read is captured into rdata byte k.
  - If k = len−1, go to DONE. Otherwise k++ and w = 0.
- mem_addr holds its value between slots and after completion.
- DONE: rsp_valid = 1 and rsp_err = 0, then go to IDLE.
- Read result assembly:
  - Bytes at index ≥ len are zero.
  - With req_sext, they are copies of bit 7 of byte len−1.
  - For writes, rsp_rdata = 0.
- ERR: rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, then go to IDLE.
- req_valid while not in IDLE is ignored; there is no queuing.
- Reset (including mid-access):
  - Next cycle: state IDLE, req_ready = 1, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, mem_addr = 0, mem_data_write = 0, mem_do_write = 0.
  - A partially completed access produces no response.

## Timing
- Accept in cycle T. Byte k's address is driven in cycle T+1+k·WAIT_CYCLES.
- Read byte k is sampled in cycle T+(k+1)·WAIT_CYCLES.
- rsp_valid is high in cycle T+len·WAIT_CYCLES+1; req_ready returns the cycle after that.
- Error response: rsp_valid in cycle T+1.
- Back-to-back requests have a minimum spacing of len·WAIT_CYCLES+2 cycles.
- All outputs are registered; there is no combinational path from req_* to mem_* or rsp_*.

## Configuration
- MEM_ACCESS_SEXT_EN defined: req_sext is honoured as described above.
- MEM_ACCESS_SEXT_EN undefined: req_sext is ignored, unread bytes are always zero, and no sign-extension logic is built.

## Structure
- Shared package cpu_pkg:
  - mem_access_state_t enum (IDLE, SLOT, DONE, ERR).
  - Default constants MEM_WAIT_CYCLES = 4 and MEM_MAX_BYTES = 2, used by the CPU when instantiating.
- One sub-module, mem_slot_counter:
  - Nested w/k counters, producing slot_start, slot_end and last_slot strobes.
  - Parametrised by WAIT_CYCLES and MAX_BYTES.

## Test plan
- Read, len 2, default parameters, addr 0x1234, memory [0x1234] = 0xCD, [0x1235] = 0xAB → rsp_rdata 0xABCD, rsp_valid 9 cycles after accept.
- Write, len 2, addr 0xFFFF, wdata 0x5A3C → mem_do_write pulses with 0x3C @ 0xFFFF, then 0x5A @ 0x0000 four cycles later; exactly two strobes.
- Read, len 1, [0x0100] = 0x80:
  - req_sext = 1 → 0xFF80 with MEM_ACCESS_SEXT_EN defined.
  - req_sext = 1 → 0x0080 with the macro undefined.
  - req_sext = 0 → 0x0080.
- req_len 0 and req_len 3 (MAX_BYTES 2) → rsp_valid with rsp_err = 1 at T+1; mem_do_write is never asserted and mem_addr is unchanged.
- Reset asserted during slot 1 of a 2-byte write → mem_do_write = 0 next cycle, no rsp_valid, req_ready = 1, then a fresh read completes correctly.
- MAX_BYTES = 4, WAIT_CYCLES = 2, read len 3 from 0x2000 = {0x11, 0x22, 0x33} → 0x00332211 at T+7; req_valid pulsed mid-access is ignored.
